// File: rtl/dispense_pkg.sv
// Shared types and sizing helpers for the multi-channel stepper dispense controller.
package dispense_pkg;

    typedef enum logic [2:0] {
        IDLE,
        SETTLE,
        STEP_HI,
        STEP_LO,
        DONE
    } state_t;

    function automatic int per_cyc(input int clk_hz, input int step_hz);
        return clk_hz / step_hz;
    endfunction

    // Bits needed to hold values 0..max_count-1, never less than one.
    function automatic int cnt_w(input int max_count);
        return (max_count > 1) ? $clog2(max_count) : 1;
    endfunction

    function automatic int max2(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/step_timer.sv
// Loadable down-counter; tc is high while the count sits at zero.
module step_timer #(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         load,
    input  logic [W-1:0] load_val,
    output logic         tc
);

    logic [W-1:0] count;

    // NOTE: sequential state uses non-blocking assignments only.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count <= '0;
        end else if (load) begin
            count <= load_val;
        end else if (count != '0) begin
            count <= count - 1'b1;
        end
    end

    assign tc = (count == '0);

endmodule

// File: rtl/dispense_step_ctrl.sv
// Multi-channel stepper dispense controller: command in, timed step/dir/en out.
// Optional build macro DISP_RAMP_EN doubles the period of the first/last steps of each unit.
module dispense_step_ctrl
    import dispense_pkg::*;
#(
    parameter int CLK_HZ         = 12000000,
    parameter int STEP_HZ        = 500,
    parameter int PULSE_CYC      = 24,
    parameter int SETTLE_CYC     = 120,
    parameter int NUM_CH         = 4,
    parameter int AMT_W          = 3,
    parameter int STEPS_PER_UNIT = 200
) (
    input  logic                      clk_x1,
    input  logic                      rst,
    input  logic                      cmd_valid,
    output logic                      cmd_ready,
    input  logic [$clog2(NUM_CH)-1:0] cmd_ch,
    input  logic [AMT_W-1:0]          cmd_amt,
    input  logic                      cmd_dir,
    input  logic                      abort,
    output logic [NUM_CH-1:0]         step,
    output logic [NUM_CH-1:0]         dir,
    output logic [NUM_CH-1:0]         en,
    output logic                      busy,
    output logic [AMT_W-1:0]          units_done,
    output logic                      done,
    output logic                      aborted
);

    localparam int PER_CYC = per_cyc(CLK_HZ, STEP_HZ);
    localparam int CH_W    = $clog2(NUM_CH);
    localparam int TMR_W   = cnt_w(max2(SETTLE_CYC, 2 * PER_CYC));
    localparam int SPU_W   = cnt_w(STEPS_PER_UNIT);

    localparam logic [TMR_W-1:0] SETTLE_LD  = TMR_W'(SETTLE_CYC - 1);
    localparam logic [TMR_W-1:0] HI_LD      = TMR_W'(PULSE_CYC - 1);
    localparam logic [TMR_W-1:0] LO_LD      = TMR_W'(PER_CYC - PULSE_CYC - 1);
    localparam logic [TMR_W-1:0] LO_RAMP_LD = TMR_W'(2 * PER_CYC - PULSE_CYC - 1);
    localparam logic [SPU_W-1:0] SPU_LAST   = SPU_W'(STEPS_PER_UNIT - 1);

    state_t            state, state_next;
    logic [CH_W-1:0]   ch_q;
    logic [AMT_W-1:0]  amt_q;
    logic [SPU_W-1:0]  step_cnt;
    logic [NUM_CH-1:0] dir_q;
    logic              aborted_q;

    logic              tmr_load;
    logic [TMR_W-1:0]  tmr_val;
    logic              tmr_tc;

    logic accept, ch_ok, do_abort, unit_last, cmd_last, lo_ramp;

    assign accept    = cmd_valid && (state == IDLE);
    assign ch_ok     = int'(cmd_ch) < NUM_CH;
    assign do_abort  = abort && (state inside {SETTLE, STEP_HI, STEP_LO});
    assign unit_last = (step_cnt == SPU_LAST);
    assign cmd_last  = unit_last && ((units_done + AMT_W'(1)) == amt_q);

`ifdef DISP_RAMP_EN
    localparam int RAMP_N = (STEPS_PER_UNIT < 4) ? STEPS_PER_UNIT : 4;
    // step_cnt is the index of the step whose high phase is just ending.
    assign lo_ramp = (int'(step_cnt) < RAMP_N) ||
                     (int'(step_cnt) >= STEPS_PER_UNIT - RAMP_N);
`else
    assign lo_ramp = 1'b0;
`endif

    step_timer #(.W(TMR_W)) u_timer (
        .clk      (clk_x1),
        .rst      (rst),
        .load     (tmr_load),
        .load_val (tmr_val),
        .tc       (tmr_tc)
    );

    always_ff @(posedge clk_x1 or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // NOTE: every always_comb output gets a default first so no path infers a latch.
    always_comb begin
        state_next = state;
        tmr_load   = 1'b0;
        tmr_val    = HI_LD;
        unique case (state)
            IDLE: begin
                if (accept && ch_ok) begin
                    if (cmd_amt == '0) begin
                        state_next = DONE;
                    end else begin
                        state_next = SETTLE;
                        tmr_load   = 1'b1;
                        tmr_val    = SETTLE_LD;
                    end
                end
            end
            SETTLE: begin
                if (do_abort) begin
                    state_next = IDLE;
                end else if (tmr_tc) begin
                    state_next = STEP_HI;
                    tmr_load   = 1'b1;
                end
            end
            STEP_HI: begin
                if (do_abort) begin
                    state_next = IDLE;
                end else if (tmr_tc) begin
                    state_next = STEP_LO;
                    tmr_load   = 1'b1;
                    tmr_val    = lo_ramp ? LO_RAMP_LD : LO_LD;
                end
            end
            STEP_LO: begin
                if (do_abort) begin
                    state_next = IDLE;
                end else if (tmr_tc) begin
                    if (cmd_last) begin
                        state_next = DONE;
                    end else begin
                        state_next = STEP_HI;
                        tmr_load   = 1'b1;
                    end
                end
            end
            DONE:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // Pin outputs decode from state so an asynchronous reset drops step/en at once.
    always_comb begin
        step      = '0;
        en        = '0;
        busy      = (state != IDLE);
        cmd_ready = (state == IDLE);
        done      = (state == DONE);
        if (state inside {SETTLE, STEP_HI, STEP_LO}) begin
            en[ch_q] = 1'b1;
        end
        if (state == STEP_HI) begin
            step[ch_q] = 1'b1;
        end
    end

    assign dir     = dir_q;
    assign aborted = aborted_q;

    always_ff @(posedge clk_x1 or posedge rst) begin
        if (rst) begin
            ch_q       <= '0;
            amt_q      <= '0;
            dir_q      <= '0;
            step_cnt   <= '0;
            units_done <= '0;
            aborted_q  <= 1'b0;
        end else begin
            aborted_q <= 1'b0;
            if (accept) begin
                ch_q       <= cmd_ch;
                amt_q      <= cmd_amt;
                units_done <= '0;
                step_cnt   <= '0;
                if (!ch_ok) begin
                    aborted_q <= 1'b1;
                end else if (cmd_amt != '0) begin
                    dir_q[cmd_ch] <= cmd_dir;
                end
            end else if (do_abort) begin
                // Abort freezes the counters, so a coincident completion is dropped.
                aborted_q <= 1'b1;
            end else if ((state == STEP_LO) && tmr_tc) begin
                if (unit_last) begin
                    step_cnt   <= '0;
                    units_done <= units_done + AMT_W'(1);
                end else begin
                    step_cnt <= step_cnt + SPU_W'(1);
                end
            end
        end
    end

endmodule
